// File: rtl/freq_div_pkg.sv
// -----------------------------------------------------------------------------
// freq_div_pkg
// Shared types and defaults for the programmable frequency-divider datapath.
//   fd_state_t : sequencing state of the divider (IDLE/ARMED/RUN/DONE)
//   DW_DEF     : default divisor width
//   PW_DEF     : default period-count width
// -----------------------------------------------------------------------------
package freq_div_pkg;

   localparam int DW_DEF = 8;
   localparam int PW_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } fd_state_t;

endpackage

// File: rtl/freq_div_datapath_counter.sv
// -----------------------------------------------------------------------------
// div_down_counter
// Half-period down-counter for the frequency divider. Counts down while
// enabled; at terminal count (cnt <= 1) it reloads ld_val on the next
// enabled cycle instead of decrementing, so the value never drops below 1
// once running (a loaded 0 behaves like 1).
// Ports:
//   clk    in  1  clock, rising edge
//   rst    in  1  asynchronous reset, active-high
//   clr    in  1  synchronous clear to 0 (wins over ld/en)
//   ld     in  1  load ld_val
//   ld_val in  W  load / reload value
//   en     in  1  count enable
//   term   out 1  terminal count, cnt <= 1
// -----------------------------------------------------------------------------
module div_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         en,
   output logic         term
);

   logic [W-1:0] cnt;

   assign term = (cnt <= W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (ld) begin
         cnt <= ld_val;
      end else if (en) begin
         if (term) begin
            cnt <= ld_val;
         end else begin
            cnt <= cnt - W'(1);
         end
      end
   end

endmodule

// File: rtl/freq_div_datapath.sv
// -----------------------------------------------------------------------------
// freq_div_datapath
// Programmable frequency-divider datapath driven by a start/count/load/divide
// sequencing controller. An lds pulse captures the divisor and period count;
// while endiv is held the block produces a 50% duty waveform with half-period
// max(div,1) cycles for nper full periods, then raises zoz until clear or the
// next lds.
//
// Optional build macro FREQ_DIV_STATUS_EN adds status outputs:
//   periods  out PW  completed full periods (per_cnt)
//   overrun  out 1   sticky: lds arrived while running (cleared by clear/rst)
//
// Ports:
//   clk      in  1   clock, rising edge
//   rst      in  1   asynchronous reset, active-high
//   clear    in  1   synchronous clear of all state (beats lds/endiv)
//   lds      in  1   load strobe
//   div_in   in  DW  divisor (0 and 1 both give a half-period of 1 cycle)
//   nper     in  PW  number of full output periods
//   endiv    in  1   run enable; low freezes all counters
//   wave_out out 1   divided waveform
//   tick     out 1   half-period boundary pulse (combinational)
//   zoz      out 1   run complete (level)
//   busy     out 1   ARMED or RUN
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset/clear, nothing loaded
// ARMED | divisor/period count loaded, waiting for endiv
// RUN   | generating wave_out; lds ignored
// DONE  | nper periods generated, zoz high until lds or clear
// -----------------------------------------------------------------------------
module freq_div_datapath
   import freq_div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          lds,
   input  logic [DW-1:0] div_in,
   input  logic [PW-1:0] nper,
   input  logic          endiv,
   output logic          wave_out,
   output logic          tick,
   output logic          zoz,
   output logic          busy
`ifdef FREQ_DIV_STATUS_EN
   ,
   output logic [PW-1:0] periods,
   output logic          overrun
`endif
);

   fd_state_t     state;
   fd_state_t     state_nxt;

   logic [DW-1:0] div_reg;
   logic [PW-1:0] per_reg;
   logic [PW-1:0] per_cnt;

   logic          load_ok;
   logic          run_en;
   logic          term;
   logic          fall;
   logic          last_per;
   logic [DW-1:0] cnt_ld_val;

   // lds is honoured everywhere except RUN; clear always wins.
   assign load_ok = lds && !clear && (state != ST_RUN);

   // The ARMED cycle that sees endiv already counts as the first RUN cycle,
   // unless nothing is to be generated (per_reg == 0) or a new load wins.
   assign run_en = endiv && !clear &&
                   ((state == ST_RUN) ||
                    ((state == ST_ARMED) && !lds && (per_reg != '0)));

   assign tick     = run_en && term;
   assign fall     = tick && wave_out;
   // per_cnt stays below per_reg while running, so the +1 cannot wrap.
   assign last_per = ((per_cnt + PW'(1)) == per_reg);

   assign busy = (state == ST_ARMED) || (state == ST_RUN);

   assign cnt_ld_val = load_ok ? div_in : div_reg;

   div_down_counter #(
      .W (DW)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (clear),
      .ld     (load_ok),
      .ld_val (cnt_ld_val),
      .en     (run_en),
      .term   (term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (lds) begin
                  state_nxt = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (lds) begin
                  state_nxt = ST_ARMED;
               end else if (endiv) begin
                  state_nxt = (per_reg == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (fall && last_per) begin
                  state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               if (lds) begin
                  state_nxt = ST_ARMED;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_reg  <= '0;
         per_reg  <= '0;
         per_cnt  <= '0;
         wave_out <= 1'b0;
      end else if (clear) begin
         div_reg  <= '0;
         per_reg  <= '0;
         per_cnt  <= '0;
         wave_out <= 1'b0;
      end else if (load_ok) begin
         div_reg  <= div_in;
         per_reg  <= nper;
         per_cnt  <= '0;
         wave_out <= 1'b0;
      end else if (tick) begin
         // A falling toggle closes one full period; the final one also
         // leaves wave_out low for DONE.
         wave_out <= ~wave_out;
         if (fall) begin
            per_cnt <= per_cnt + PW'(1);
         end
      end
   end

   // zoz mirrors the DONE state one register stage after the decision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zoz <= 1'b0;
      end else begin
         zoz <= (state_nxt == ST_DONE);
      end
   end

`ifdef FREQ_DIV_STATUS_EN
   assign periods = per_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (clear) begin
         overrun <= 1'b0;
      end else if (lds && (state == ST_RUN)) begin
         overrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_freq_div_datapath.sv
module tb_freq_div_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic       lds;
   logic [7:0] div_in;
   logic [3:0] nper;
   logic       endiv;
   logic       wave_out;
   logic       tick;
   logic       zoz;
   logic       busy;
`ifdef FREQ_DIV_STATUS_EN
   logic [3:0] periods;
   logic       overrun;
`endif

   freq_div_datapath dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .lds      (lds),
      .div_in   (div_in),
      .nper     (nper),
      .endiv    (endiv),
      .wave_out (wave_out),
      .tick     (tick),
      .zoz      (zoz),
      .busy     (busy)
`ifdef FREQ_DIV_STATUS_EN
      ,
      .periods  (periods),
      .overrun  (overrun)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int w;
   } tev_t;

   tev_t exp_tick[$];
   int   exp_zoz[$];

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;
   logic zoz_prev = 1'b0;
   int   zoz_cyc = -1;
   tev_t mon_t;
   int   mon_z;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected events whenever the DUT presents one.
   always @(negedge clk) begin
      if (mon_en) begin
         if (tick === 1'b1) begin
            if (exp_tick.size() == 0) begin
               chk("spurious_tick", int'(tick), 0);
            end else begin
               mon_t = exp_tick.pop_front();
               chk("tick_cycle", cyc, mon_t.c);
               chk("wave_at_tick", int'(wave_out), mon_t.w);
            end
         end
         if (zoz === 1'b1 && zoz_prev !== 1'b1) begin
            zoz_cyc = cyc;
            if (exp_zoz.size() == 0) begin
               chk("spurious_zoz", int'(zoz), 0);
            end else begin
               mon_z = exp_zoz.pop_front();
               chk("zoz_cycle", cyc, mon_z);
               chk("wave_at_done", int'(wave_out), 0);
            end
         end
      end
      zoz_prev = zoz;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: ticks fall on every max(div,1)-th enabled cycle after the
   // load, 2*nper of them; wave_out is high between odd and even ticks;
   // zoz rises the cycle after the last tick (or after the first enabled
   // cycle when nper is 0).
   // mode 0: endiv always high, 1: random endiv, 2: 3-cycle pause after the
   // first tick, 3: extra lds issued while running (must be ignored).
   task automatic run_case(input int dv, input int np, input int mode, output int load_cyc);
      int   half;
      int   e;
      int   k;
      int   pause_left;
      int   steps;
      bit   done;
      bit   mid_done;
      bit   en;
      tev_t t;
      half = (dv == 0) ? 1 : dv;
      e = 0; k = 0; pause_left = 0; steps = 0; done = 0; mid_done = 0;
      lds = 1'b1;
      div_in = 8'(dv);
      nper = 4'(np);
      endiv = 1'($urandom_range(0, 1));
      load_cyc = cyc;
      step();
      div_in = 8'($urandom);
      nper = 4'($urandom);
      while (!done && steps < 3000) begin
         en = 1'b1;
         if (mode == 1) en = ($urandom_range(0, 3) != 0);
         if (mode == 2 && pause_left > 0) begin
            en = 1'b0;
            pause_left--;
         end
         lds = 1'b0;
         if (mode == 3 && k == 1 && !mid_done) begin
            lds = 1'b1;
            div_in = 8'd7;
            nper = 4'd1;
            mid_done = 1'b1;
         end
         endiv = en;
         if (en) begin
            e++;
            if (np == 0) begin
               exp_zoz.push_back(cyc + 1);
               done = 1'b1;
            end else if (e % half == 0) begin
               k++;
               t.c = cyc;
               t.w = (k % 2 == 0) ? 1 : 0;
               exp_tick.push_back(t);
               if (k == 2 * np) begin
                  exp_zoz.push_back(cyc + 1);
                  done = 1'b1;
               end
               if (mode == 2 && k == 1) pause_left = 3;
            end
         end
         step();
         steps++;
      end
      lds = 1'b0;
      for (int i = 0; i < 3; i++) begin
         endiv = 1'($urandom_range(0, 1));
         step();
      end
      chk("done_busy", int'(busy), 0);
      chk("done_zoz", int'(zoz), 1);
      chk("done_wave", int'(wave_out), 0);
      chk("pending_events", exp_tick.size() + exp_zoz.size(), 0);
   endtask

   int L;

   initial begin
      rst = 1'b1; clear = 1'b0; lds = 1'b0; endiv = 1'b0;
      div_in = '0; nper = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wave", int'(wave_out), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_zoz", int'(zoz), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      step();
      mon_en = 1'b1;

      run_case(3, 2, 0, L);
      chk("div3_np2_zoz_rel", zoz_cyc - L, 13);

      run_case(0, 1, 0, L);
      chk("div0_np1_zoz_rel", zoz_cyc - L, 3);
      lds = 1'b1; div_in = 8'd4; nper = 4'd1; endiv = 1'b0;
      step();
      lds = 1'b0;
      chk("lds_clears_zoz", int'(zoz), 0);
      chk("lds_arms_busy", int'(busy), 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear_busy", int'(busy), 0);

      run_case(5, 0, 0, L);
      chk("np0_zoz_rel", zoz_cyc - L, 2);

      run_case(2, 1, 2, L);
      chk("pause_zoz_rel", zoz_cyc - L, 8);

      run_case(2, 2, 3, L);
      chk("lds_in_run_zoz_rel", zoz_cyc - L, 9);
`ifdef FREQ_DIV_STATUS_EN
      chk("overrun_set", int'(overrun), 1);
      chk("periods_done", int'(periods), 2);
`endif

      // lds together with clear: clear wins, nothing armed.
      lds = 1'b1; clear = 1'b1; div_in = 8'd5; nper = 4'd3; endiv = 1'b0;
      step();
      lds = 1'b0; clear = 1'b0;
      chk("ldsclr_busy", int'(busy), 0);
      chk("ldsclr_zoz", int'(zoz), 0);
      chk("ldsclr_wave", int'(wave_out), 0);
`ifdef FREQ_DIV_STATUS_EN
      chk("ldsclr_overrun", int'(overrun), 0);
      chk("ldsclr_periods", int'(periods), 0);
`endif
      endiv = 1'b1;
      repeat (6) step();
      endiv = 1'b0;
      chk("idle_stays_idle", int'(busy), 0);

      // Asynchronous reset in the middle of a run.
      mon_en = 1'b0;
      lds = 1'b1; div_in = 8'd3; nper = 4'd2; endiv = 1'b0;
      step();
      lds = 1'b0; endiv = 1'b1;
      repeat (4) step();
      chk("pre_rst_busy", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_wave", int'(wave_out), 0);
      chk("midrst_tick", int'(tick), 0);
      chk("midrst_zoz", int'(zoz), 0);
      chk("midrst_busy", int'(busy), 0);
      step();
      rst = 1'b0; endiv = 1'b0;
      exp_tick.delete();
      exp_zoz.delete();
      step();
      mon_en = 1'b1;

      for (int r = 0; r < 20; r++) begin
         run_case($urandom_range(0, 9), $urandom_range(0, 5),
                  $urandom_range(0, 3), L);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
